// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: W-stage writeback has priority, secondary writes queue in a FIFO.
// Optional trace output is compiled in with GRF_WB_ARBITER_TRACE_EN.
module grf_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_we,
   input  logic [4:0]  w_addr,
   input  logic [31:0] w_data,
   input  logic        s_valid,
   input  logic [4:0]  s_addr,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic        grf_we,
   output logic [4:0]  grf_waddr,
   output logic [31:0] grf_wdata,
   output logic [31:0] pending_mask,
   output logic        stall_req
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int WW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [WW-1:0] LIMIT    = WW'(STARVE_LIMIT);

   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [AW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [31:0]      pend_q, pend_d;

   logic empty, full, head_vld, w_real, accept, push, pop, stall, gnt_w, gnt_s;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == FULL_CNT);
   assign head_vld = !empty && vld_q[rd_q];
   assign w_real   = w_we && (w_addr != 5'd0);
   assign accept   = s_valid && !full && !reset;
   // Writes to $0 complete the handshake but never occupy a slot.
   assign push     = accept && (s_addr != 5'd0);
   assign stall    = !reset && head_vld && (wait_q >= LIMIT);

   always_comb begin
      gnt_w = 1'b0;
      gnt_s = 1'b0;
      pop   = 1'b0;
      if (!reset) begin
         if (stall) begin
            gnt_s = 1'b1;
            pop   = 1'b1;
         end else if (w_real) begin
            gnt_w = 1'b1;
            pop   = !empty && !head_vld;
         end else if (head_vld) begin
            gnt_s = 1'b1;
            pop   = 1'b1;
         end else begin
            pop   = !empty;
         end
      end
   end

   assign s_ready      = !full && !reset;
   assign stall_req    = stall;
   assign grf_we       = gnt_w || gnt_s;
   assign grf_waddr    = gnt_s ? addr_q[rd_q] : (gnt_w ? w_addr : 5'd0);
   assign grf_wdata    = gnt_s ? data_q[rd_q] : (gnt_w ? w_data : 32'd0);
   assign pending_mask = reset ? 32'd0 : pend_q;

   always_comb begin
      vld_d  = vld_q;
      pend_d = '0;
      // Squash older copies first; a same-cycle push is newer and lands valid.
      for (int i = 0; i < DEPTH; i++) begin
         if (gnt_w && (addr_q[i] == w_addr)) vld_d[i] = 1'b0;
      end
      if (pop)  vld_d[rd_q] = 1'b0;
      if (push) vld_d[wr_q] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_d[i]) begin
            if (push && (wr_q == AW'(i))) pend_d[s_addr]    = 1'b1;
            else                          pend_d[addr_q[i]] = 1'b1;
         end
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (pop || !head_vld) wait_d = '0;
      else if (wait_q == LIMIT) wait_d = wait_q;
      else wait_d = wait_q + WW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= '0;
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         wait_q <= '0;
         pend_q <= '0;
      end else begin
         vld_q  <= vld_d;
         rd_q   <= rd_q + AW'(pop);
         wr_q   <= wr_q + AW'(push);
         cnt_q  <= cnt_d;
         wait_q <= wait_d;
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_q] <= s_addr;
         data_q[wr_q] <= s_data;
      end
   end

`ifdef GRF_WB_ARBITER_TRACE_EN
   always @(posedge clk) begin
      if (grf_we && (grf_waddr != 5'd0))
         $display("%d@ %s $%d <= %h", $time, gnt_s ? "S" : "W", grf_waddr, grf_wdata);
      for (int i = 0; i < DEPTH; i++) begin
         if (gnt_w && vld_q[i] && (addr_q[i] == w_addr))
            $display("%d@ squash entry %0d $%d", $time, i, addr_q[i]);
      end
   end
`endif

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Sequences the single GRF write port between two sources: the W-stage writeback (primary, program-ordered) and a secondary long-latency requester (MDU/loader style) using a valid/ready handshake.
- Secondary writes are buffered in a small FIFO and drained into free write-port slots.
- Exports a pending-register scoreboard for the hazard unit, plus a starvation stall request so secondary writes cannot wait forever.
- Sits between the W-stage pipeline register / secondary unit and the GRF write port.

Parameters:
- DEPTH, 2, secondary FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 4, cycles a valid FIFO head may wait before stall_req asserts (>=1).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- w_we  input  1  W-stage write enable
- w_addr  input  5  W-stage destination register
- w_data  input  32  W-stage write data
- s_valid  input  1  secondary write request
- s_addr  input  5  secondary destination register
- s_data  input  32  secondary write data
- s_ready  output  1  FIFO can accept (= !full && !reset)
- grf_we  output  1  to GRF RegWrite
- grf_waddr  output  5  to GRF WriteReg
- grf_wdata  output  32  to GRF WriteData
- pending_mask  output  32  bit r=1 if a valid queued secondary write targets r
- stall_req  output  1  to hazard unit: freeze pipeline this cycle

Behaviour:
- Reset (sync, active-high): FIFO empty, all entry valid bits 0, wait_cnt=0. While reset=1: grf_we=0, s_ready=0, stall_req=0, pending_mask=0.
- w_real = w_we && w_addr!=0. An s handshake with s_addr==0 is accepted and discarded (no enqueue).
- Handshake: accept when s_valid && s_ready; data enqueues at the clock edge.
  - s_ready depends only on current occupancy; no pass-through when full even if a pop occurs the same cycle.
  - Minimum secondary latency: accept at edge N, earliest grf_we at cycle N+1.
- Port grant (combinational, each cycle):
  - stall_req=1: grant the FIFO head; the W write is NOT performed. The pipeline holds the W registers stable, so W retries next cycle.
  - Otherwise, w_real=1: grant W (grf_we=1, grf_waddr=w_addr, grf_wdata=w_data).
  - Otherwise, FIFO head valid: grant head, pop at edge.
  - Otherwise grf_we=0.
- Squash rule: when a W write is performed to register r, every queued entry with addr r is invalidated at that edge (W value is newer).
  - A secondary entry accepted in the same cycle as a W write to the same r is newer: it is enqueued valid and not squashed.
- An invalid head pops in any cycle without using the port. At most one pop per cycle.
- pending_mask = OR of one-hot(addr) over valid entries; registered from FIFO state, updated at the edge.
- Starvation counter: wait_cnt increments each cycle a valid head exists and is not granted; clears on pop or when FIFO empty.
  - stall_req = (wait_cnt >= STARVE_LIMIT) && head valid. It drops the cycle after the head drains.
- Occupancy wraps via pointer modulo DEPTH. Full plus squash of all entries: entries still occupy slots until popped (one per cycle).
- Reset mid-operation discards all queued writes; none reach the GRF.

Optional Feature:
- Macro GRF_WB_ARBITER_TRACE_EN.
- Defined: on every clock edge with grf_we=1 and grf_waddr!=0, $display("%d@ %s $%d <= %h", $time, src, grf_waddr, grf_wdata), where src is "W" or "S". Also $display a note for each squashed entry.
- Undefined: no display code compiled; functional behaviour identical.

Test Plan:
- Idle: W writes $5=0x1234 with FIFO empty -> grf_we=1, waddr=5, wdata=0x1234 same cycle; pending_mask=0.
- Secondary fill: s_valid with $8=0xA, $9=0xB on consecutive cycles while w_we=1 continuously to $3 -> s_ready=0 after 2 accepts; pending_mask=0x300.
- Starvation (same setup): stall_req=1 after STARVE_LIMIT=4 waiting cycles; $8 written, then $9 written one stall later; W $3 write deferred during stall cycles.
- Squash: queue $7=0x77, then W writes $7=0x99 -> pending_mask bit7 clears next edge; $7 never receives 0x77; head pops without grf_we.
- Same-cycle conflict: W $4=0x1 and s accept $4=0x2 in the same cycle -> W writes 0x1 now; next free cycle writes 0x2; final $4=0x2.
- $0 and reset: s $0=0xFF accepted, pending_mask unchanged, no write. Reset asserted with 2 queued entries -> next cycle s_ready=1, pending_mask=0, no GRF write from old entries.
